serial_transmitter: RTL and testbench
=====================================

# serial_transmitter

- Transmit half of the UART link: serialises bytes from the host logic onto `TxD` as 8N1 frames, LSB first. Frame format and bit rate match the on-board receive path.
- A small FIFO lets game logic queue several bytes back-to-back without waiting on the line.
- Sits between the controller logic and the physical TX pin; a receiver instance at the far end sees a continuous stream of frames.

## Interface
- `CLK_FREQ`, 50000000, clock frequency in Hz
- `BAUD`, 115200, line bit rate in bit/s
- `FIFO_DEPTH`, 4, byte entries in the queue; power of two, ≥2
- `clock`  input  1  system clock; all logic on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `TxD_start`  input  1  push request; one byte written per cycle while high and `TxD_full` low
- `TxD_data`  input  8  byte to queue, sampled with `TxD_start`
- `TxD_full`  output  1  FIFO holds `FIFO_DEPTH` bytes; pushes ignored
- `TxD_busy`  output  1  high while a frame is on the line or the FIFO is non-empty
- `TxD`  output  1  serial line, idle high

## Operation
- Bit divider `DIV = (CLK_FREQ + BAUD/2) / BAUD`, rounded to nearest (434 at the defaults).
- The bit counter reloads at every bit boundary. Every bit lasts exactly `DIV` clocks.
- FIFO: circular buffer with read/write pointers and an occupancy count of width `clog2(FIFO_DEPTH)+1`. Pointers wrap modulo `FIFO_DEPTH`.
- Push rules:
  - A push is accepted iff `TxD_start`=1 and registered `TxD_full`=0.
  - A push while full is dropped silently, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- States: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: `TxD`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `TxD`=0 for `DIV` clocks, then DATA.
  - DATA: shift out bits 0..7, LSB first, `DIV` clocks each, using a 3-bit index. After bit 7, go to PARITY if configured, else STOP.
  - STOP: `TxD`=1 for `DIV` clocks. At the end of STOP:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- `TxD_busy` = (state ≠ IDLE) | (count ≠ 0).
- Reset, at any time including mid-frame:
  - state IDLE, FIFO emptied, pointers and counters cleared.
  - Output reset values: `TxD`=1, `TxD_busy`=0, `TxD_full`=0.
  - A partially sent frame is abandoned.

## Timing
- A push accepted at edge N is visible in the count at N+1; `TxD_full` and `TxD_busy` update at N+1.
- With the FIFO empty and state IDLE:
  - push at edge N → pop and START entry at N+1 → `TxD` falls low at N+1.
- Frame duration is exactly 10·`DIV` clocks (11·`DIV` with parity). Back-to-back frames have no gap.
- `TxD` is driven from a register, glitch-free, with no combinational path from inputs.
- `TxD_full` deasserts the cycle after the pop that frees an entry.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - Adds a PARITY state after data bit 7, lasting `DIV` clocks.
  - Drives even parity: the XOR of the 8 data bits.
  - Frame becomes 8E1, 11·`DIV` clocks.
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10·`DIV` clocks.

## Test plan
Unless noted, all scenarios use `CLK_FREQ`=1000000, `BAUD`=100000, so `DIV`=10.
- Single byte: push 0x55 from idle → `TxD` low 10 clocks, then 1,0,1,0,1,0,1,0 (10 clocks each), then high 10 clocks; `TxD_busy` low exactly 100 clocks after going high.
- Back-to-back burst: push 0xA3, 0x0F, 0xFF on consecutive cycles → three contiguous frames with no idle between STOP and next START; receiver model decodes 0xA3, 0x0F, 0xFF in order.
- Overflow with `FIFO_DEPTH`=4: push 6 bytes 0x01..0x06 on consecutive cycles from idle.
  - The first byte is popped at once, so 0x01..0x05 are accepted.
  - `TxD_full` asserts after the 5th accepted push; 0x06 is dropped.
  - The line carries exactly 0x01..0x05.
- Reset mid-frame: assert `reset_n`=0 during data bit 3 of 0x00 with 2 bytes queued.
  - `TxD`=1, `TxD_busy`=0, `TxD_full`=0 immediately.
  - After release, the line stays idle high 50 clocks.
- Parity with `SERIAL_TX_PARITY_EN`: send 0x07 → parity bit 1; send 0x03 → parity bit 0; each frame 110 clocks.
- Divider rounding: `CLK_FREQ`=50000000, `BAUD`=115200 → measured bit period 434 clocks.

Source files
------------

// File: rtl/serial_transmitter.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module serial_transmitter #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_full,
  output logic       TxD_busy,
  output logic       TxD
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             full_q;
  logic             busy_q;
  logic             txd_q;

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  logic       bit_end_c;
  logic       push_c;
  logic       pop_c;
  logic       idle_next_c;
  logic [7:0] head_c;

  // Pops happen only when the line is free: from IDLE or at the very end of STOP.
  always_comb begin
    bit_end_c   = (baud_cnt_q == '0);
    push_c      = TxD_start && !full_q;
    pop_c       = (occ_q != '0) &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_c));
    idle_next_c = !pop_c &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_c));
    head_c      = mem_q[rd_ptr_q];
    occ_d       = occ_q;
    if (push_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !push_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= TxD_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q  <= occ_d;
      full_q <= (occ_d == DEPTH_C);
    end
  end

  // Frame sequencer; every non-idle state lasts DIV clocks via baud_cnt_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      busy_q <= !idle_next_c || (occ_q != '0);
      if (state_q != S_IDLE) begin
        baud_cnt_q <= bit_end_c ? DIV_M1 : (baud_cnt_q - CNT_W'(1));
      end
      if (pop_c) begin
        state_q    <= S_START;
        baud_cnt_q <= DIV_M1;
        shift_q    <= head_c;
        txd_q      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_q      <= ^head_c;
`endif
      end else if ((state_q != S_IDLE) && bit_end_c) begin
        case (state_q)
          S_START: begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          S_PARITY: begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
`endif
          default: begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TxD_full = full_q;
  assign TxD_busy = busy_q;
  assign TxD      = txd_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: framing, burst, overflow, reset, divider.
module tb_serial_transmitter;

  localparam int unsigned DIV = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned BIT_N = 11;
`else
  localparam int unsigned BIT_N = 10;
`endif
  localparam int unsigned FRAME = BIT_N * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full, busy, txd;

  logic       d_start = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_full, d_busy, d_txd;

  int total = 0;
  int bad   = 0;
  int bh, n, errs;
  logic [5:0] full_exp;

  always #5 clk = ~clk;

  serial_transmitter #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clock(clk), .reset_n(rst_n), .TxD_start(start), .TxD_data(data),
    .TxD_full(full), .TxD_busy(busy), .TxD(txd)
  );

  serial_transmitter dut_d (
    .clock(clk), .reset_n(rst_n), .TxD_start(d_start), .TxD_data(d_data),
    .TxD_full(d_full), .TxD_busy(d_busy), .TxD(d_txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_low(input string tag);
    int k;
    k = 0;
    while (txd !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(txd), 32'd0);
  endtask

  // Compares every line sample of one frame and decodes it at mid-bit like a receiver.
  task automatic check_frame(input string tag, input logic [7:0] d, input int skip,
                             output int busy_hi);
    logic [10:0] exp_v;
    logic [7:0]  got;
    int          e;
    exp_v    = '1;
    exp_v[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_v[1+i] = d[i];
`ifdef SERIAL_TX_PARITY_EN
    exp_v[9] = ^d;
`endif
    e = 0;
    got = '0;
    busy_hi = 0;
    for (int i = skip; i < int'(FRAME); i++) begin
      if (txd !== exp_v[i/DIV]) e++;
      if ((i % DIV) == DIV/2 && (i/DIV) >= 1 && (i/DIV) <= 8) got[i/DIV-1] = txd;
      if (busy === 1'b1) busy_hi++;
      @(negedge clk);
    end
    check({tag, "_bits"}, 32'(e), 32'd0);
    check({tag, "_byte"}, 32'(got), 32'(d));
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte 0x55
    push(8'h55);
    check("single_pre_txd", 32'(txd), 32'd1);
    check("single_pre_busy", 32'(busy), 32'd0);
    wait_low("single_start");
    check("single_busy_hi", 32'(busy), 32'd1);
    check_frame("single55", 8'h55, 0, bh);
    check("single_busy_len", 32'(bh), 32'(FRAME));
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_txd_end", 32'(txd), 32'd1);

    // back-to-back burst; first byte popped one edge after its push
    push(8'hA3);
    push(8'h0F);
    push(8'hFF);
    check_frame("burstA3", 8'hA3, 1, bh);
    check_frame("burst0F", 8'h0F, 0, bh);
    check_frame("burstFF", 8'hFF, 0, bh);
    check("burst_txd_end", 32'(txd), 32'd1);
    repeat (2) @(negedge clk);
    check("burst_busy_end", 32'(busy), 32'd0);

    // parity-sensitive bytes
    push(8'h07);
    wait_low("p07_start");
    check_frame("p07", 8'h07, 0, bh);
    check("p07_busy_len", 32'(bh), 32'(FRAME));
    push(8'h03);
    wait_low("p03_start");
    check_frame("p03", 8'h03, 0, bh);
    repeat (2) @(negedge clk);

    // overflow: six pushes, 0x06 must be dropped
    full_exp = 6'b110000;
    for (int i = 0; i < 6; i++) begin
      push(8'(i + 1));
      check($sformatf("ovf_full%0d", i), 32'(full), 32'(full_exp[i]));
    end
    check_frame("ovf01", 8'h01, 4, bh);
    check("ovf_full_clear", 32'(full), 32'd0);
    check_frame("ovf02", 8'h02, 0, bh);
    check_frame("ovf03", 8'h03, 0, bh);
    check_frame("ovf04", 8'h04, 0, bh);
    check_frame("ovf05", 8'h05, 0, bh);
    errs = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("ovf_no_sixth", 32'(errs), 32'd0);

    // reset during data bit 3 of 0x00 with two bytes queued
    push(8'h00);
    push(8'h11);
    push(8'h22);
    repeat (44) @(negedge clk);
    check("midrst_pre_txd", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("midrst_idle50", 32'(errs), 32'd0);

    // default divider (50 MHz / 115200 -> 434)
    d_start = 1'b1;
    d_data  = 8'h55;
    @(negedge clk);
    d_start = 1'b0;
    n = 0;
    while (d_txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("div_start_seen", 32'(d_txd), 32'd0);
    n = 0;
    while (d_txd === 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("div_start_len", 32'(n), 32'd434);
    n = 0;
    while (d_txd === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("div_bit0_len", 32'(n), 32'd434);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
